ibex_lsu_resp_unit: RTL

IBEX_LSU_RESP_UNIT -- requirements
Module: ibex_lsu_resp_unit

---
 rtl/ibex_lsu_resp_unit.sv | 109 ++++++++++
 1 files changed

// File: rtl/ibex_lsu_resp_unit.sv
// LSU response unit: tracks granted data-bus requests in a small FIFO and turns
// each bus response into formatted load data or a load/store error in the same cycle.
module ibex_lsu_resp_unit #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_type_i,
    input  logic        req_sign_ext_i,
    input  logic [1:0]  req_offset_i,
    output logic        req_ready_o,

    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i,

    output logic [31:0] rf_wdata_lsu_o,
    output logic        rf_we_lsu_o,
    output logic        lsu_data_valid_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic [2:0]  outstanding_o
);

    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned Depth = 1 << PtrW;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sign_ext;
        logic [1:0] offset;
    } entry_t;

    entry_t          entries_q [Depth];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [2:0]      count_q;

    logic        push, pop;
    entry_t      head;
    logic [31:0] shifted;
    logic [31:0] formatted;

    // Pointers wrap at MaxOutstanding, which need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign req_ready_o   = (count_q < 3'(MaxOutstanding));
    assign push          = req_valid_i & req_ready_o;
    assign pop           = data_rvalid_i & (count_q != 3'd0);
    assign outstanding_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 3'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
            if (push && !pop) begin
                count_q <= count_q + 3'd1;
            end else if (!push && pop) begin
                count_q <= count_q - 3'd1;
            end
        end
    end

    // Payload is only read behind a nonzero count, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            entries_q[wptr_q] <= '{we: req_we_i, size: req_type_i,
                                   sign_ext: req_sign_ext_i, offset: req_offset_i};
        end
    end

    assign head    = entries_q[rptr_q];
    assign shifted = data_rdata_i >> {head.offset, 3'b000};

    always_comb begin
        formatted = shifted;
        case (head.size)
            2'b01:   formatted = {{16{head.sign_ext & shifted[15]}}, shifted[15:0]};
            2'b10:   formatted = {{24{head.sign_ext & shifted[7]}}, shifted[7:0]};
            default: formatted = shifted;
        endcase
    end

    assign lsu_data_valid_o = pop;
    assign rf_we_lsu_o      = pop & ~head.we & ~data_err_i;
    assign rf_wdata_lsu_o   = rf_we_lsu_o ? formatted : 32'd0;
    assign load_err_o       = pop & ~head.we & data_err_i;
    assign store_err_o      = pop & head.we & data_err_i;

`ifndef SYNTHESIS
    push_while_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(req_valid_i && !req_ready_o))
        else $warning("request dropped: outstanding queue full");

    resp_while_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(data_rvalid_i && count_q == 3'd0))
        else $warning("response ignored: no outstanding request");
`endif

endmodule
